// File: rtl/mips_mc_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, functs,
// ALU control codes, mux selects and the FSM state enum.
package mips_mc_control_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REGB    = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
   } state_t;

   function automatic logic funct_supported(input logic [5:0] f);
      return f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
   endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Control-to-datapath bundle: instruction fields and status in, strobes and selects out.
interface mips_mc_control_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pcEn;
   logic       iOrD;
   logic       memRead;
   logic       memWrite;
   logic       irWrite;
   logic       regDst;
   logic       memToReg;
   logic       regWrite;
   logic       aluSrcA;
   logic [1:0] aluSrcB;
   logic [1:0] pcSrc;
   logic [2:0] aluControl;
   logic       illegal_op;
   logic       mem_timeout;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output pcEn, iOrD, memRead, memWrite, irWrite, regDst, memToReg, regWrite,
             aluSrcA, aluSrcB, pcSrc, aluControl, illegal_op, mem_timeout
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  pcEn, iOrD, memRead, memWrite, irWrite, regDst, memToReg, regWrite,
             aluSrcA, aluSrcB, pcSrc, aluControl, illegal_op, mem_timeout
   );
endinterface

// File: rtl/mips_mc_control_alu_decoder.sv
// ALU decoder: maps the FSM's aluOp and the R-type funct field to the 3-bit ALU control.
import mips_mc_control_pkg::*;

module alu_decoder (
   input  aluop_t     aluOp,
   input  logic [5:0] funct,
   output logic [2:0] aluControl
);
   always_comb begin
      aluControl = ALU_ADD;
      case (aluOp)
         ALUOP_SUB: aluControl = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_SUB:  aluControl = ALU_SUB;
               FN_AND:  aluControl = ALU_AND;
               FN_OR:   aluControl = ALU_OR;
               FN_SLT:  aluControl = ALU_SLT;
               default: aluControl = ALU_ADD;
            endcase
         end
         default: aluControl = ALU_ADD;
      endcase
   end
endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM with memory wait-state timeout detection.
// Optional: define BNE_EN to add bne (opcode 000101) through the BRANCH state.
import mips_mc_control_pkg::*;

module mips_mc_control #(
   parameter int MEM_TIMEOUT = 16
) (
   input logic             clk,
   input logic             reset,
   mips_mc_control_if.master bus
);
   localparam int CW = $clog2(MEM_TIMEOUT) + 1;

   state_t         state, state_next;
   logic [CW-1:0]  wait_cnt;
   logic           mem_timeout_q;
   logic           is_wait;
   logic           branch_taken;
   aluop_t         aluop;
   logic [2:0]     alu_ctl;

   alu_decoder u_alu_dec (
      .aluOp      (aluop),
      .funct      (bus.funct),
      .aluControl (alu_ctl)
   );

   assign is_wait = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

`ifdef BNE_EN
   assign branch_taken = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
`else
   assign branch_taken = bus.zero;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_FETCH;
         wait_cnt      <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state <= state_next;
         if (is_wait && !bus.mem_ready) begin
            if (wait_cnt != CW'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + CW'(1);
            if (wait_cnt == CW'(MEM_TIMEOUT - 1)) mem_timeout_q <= 1'b1;
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   // NOTE: every output is given a default before the case so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_next     = state;
      aluop          = ALUOP_ADD;
      bus.pcEn       = 1'b0;
      bus.iOrD       = 1'b0;
      bus.memRead    = 1'b0;
      bus.memWrite   = 1'b0;
      bus.irWrite    = 1'b0;
      bus.regDst     = 1'b0;
      bus.memToReg   = 1'b0;
      bus.regWrite   = 1'b0;
      bus.aluSrcA    = 1'b0;
      bus.aluSrcB    = SRCB_REGB;
      bus.pcSrc      = PCSRC_ALU;
      bus.illegal_op = 1'b0;
      if (!reset) begin
         case (state)
            S_FETCH: begin
               bus.memRead = 1'b1;
               bus.aluSrcB = SRCB_FOUR;
               bus.irWrite = bus.mem_ready;
               bus.pcEn    = bus.mem_ready;
               if (bus.mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
               bus.aluSrcB = SRCB_IMM_SL2;
               case (bus.opcode)
                  OP_LW, OP_SW: state_next = S_MEMADR;
                  OP_RTYPE: begin
                     if (funct_supported(bus.funct)) state_next = S_EXEC;
                     else begin
                        bus.illegal_op = 1'b1;
                        state_next     = S_FETCH;
                     end
                  end
                  OP_BEQ:  state_next = S_BRANCH;
`ifdef BNE_EN
                  OP_BNE:  state_next = S_BRANCH;
`endif
                  OP_ADDI: state_next = S_ADDIEX;
                  OP_J:    state_next = S_JUMP;
                  default: begin
                     bus.illegal_op = 1'b1;
                     state_next     = S_FETCH;
                  end
               endcase
            end
            S_MEMADR: begin
               bus.aluSrcA = 1'b1;
               bus.aluSrcB = SRCB_IMM;
               state_next  = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
               bus.iOrD    = 1'b1;
               bus.memRead = 1'b1;
               if (bus.mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
               bus.memToReg = 1'b1;
               bus.regWrite = 1'b1;
               state_next   = S_FETCH;
            end
            S_MEMWR: begin
               bus.iOrD     = 1'b1;
               bus.memWrite = 1'b1;
               if (bus.mem_ready) state_next = S_FETCH;
            end
            S_EXEC: begin
               bus.aluSrcA = 1'b1;
               aluop       = ALUOP_FUNCT;
               state_next  = S_ALUWB;
            end
            S_ALUWB: begin
               bus.regDst   = 1'b1;
               bus.regWrite = 1'b1;
               state_next   = S_FETCH;
            end
            S_BRANCH: begin
               bus.aluSrcA = 1'b1;
               aluop       = ALUOP_SUB;
               bus.pcSrc   = PCSRC_ALUOUT;
               bus.pcEn    = branch_taken;
               state_next  = S_FETCH;
            end
            S_ADDIEX: begin
               bus.aluSrcA = 1'b1;
               bus.aluSrcB = SRCB_IMM;
               state_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
               bus.regWrite = 1'b1;
               state_next   = S_FETCH;
            end
            S_JUMP: begin
               bus.pcSrc  = PCSRC_JUMP;
               bus.pcEn   = 1'b1;
               state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
         endcase
      end
   end

   assign bus.aluControl  = reset ? 3'b000 : alu_ctl;
   assign bus.mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: per-cycle strobe vectors per instruction class,
// memory wait states, timeout, illegal opcodes and reset mid-instruction.
module tb_mips_mc_control;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   mips_mc_control_if bus ();

   mips_mc_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // {pcEn,iOrD,memRead,memWrite,irWrite,regDst,memToReg,regWrite,aluSrcA,aluSrcB,pcSrc,aluControl,illegal_op}
   function automatic logic [16:0] pack();
      return {bus.pcEn, bus.iOrD, bus.memRead, bus.memWrite, bus.irWrite, bus.regDst,
              bus.memToReg, bus.regWrite, bus.aluSrcA, bus.aluSrcB, bus.pcSrc,
              bus.aluControl, bus.illegal_op};
   endfunction

   // Expected {mask, value}; a negative argument marks that field don't-care.
   function automatic logic [33:0] ev(int pcen, int iord, int mrd, int mwr, int irw, int rdst,
                                      int m2r, int rw, int sa, int sb, int ps, int ac, int ill);
      logic [16:0] v, m;
      v = '0;
      m = '0;
      if (pcen >= 0) begin v[16]   = pcen[0];   m[16]   = 1'b1;   end
      if (iord >= 0) begin v[15]   = iord[0];   m[15]   = 1'b1;   end
      if (mrd  >= 0) begin v[14]   = mrd[0];    m[14]   = 1'b1;   end
      if (mwr  >= 0) begin v[13]   = mwr[0];    m[13]   = 1'b1;   end
      if (irw  >= 0) begin v[12]   = irw[0];    m[12]   = 1'b1;   end
      if (rdst >= 0) begin v[11]   = rdst[0];   m[11]   = 1'b1;   end
      if (m2r  >= 0) begin v[10]   = m2r[0];    m[10]   = 1'b1;   end
      if (rw   >= 0) begin v[9]    = rw[0];     m[9]    = 1'b1;   end
      if (sa   >= 0) begin v[8]    = sa[0];     m[8]    = 1'b1;   end
      if (sb   >= 0) begin v[7:6]  = sb[1:0];   m[7:6]  = 2'b11;  end
      if (ps   >= 0) begin v[5:4]  = ps[1:0];   m[5:4]  = 2'b11;  end
      if (ac   >= 0) begin v[3:1]  = ac[2:0];   m[3:1]  = 3'b111; end
      if (ill  >= 0) begin v[0]    = ill[0];    m[0]    = 1'b1;   end
      return {m, v};
   endfunction

   function automatic logic [33:0] e_reset();       return ev(0,-1,0,0,0,-1,-1,0,-1,-1,-1,-1,0); endfunction
   function automatic logic [33:0] e_fetch(int mr); return ev(mr,0,1,0,mr,-1,-1,0,0,1,0,2,0);     endfunction
   function automatic logic [33:0] e_decode(int il);return ev(0,-1,0,0,0,-1,-1,0,0,3,-1,2,il);    endfunction
   function automatic logic [33:0] e_memadr();      return ev(0,-1,0,0,0,-1,-1,0,1,2,-1,2,0);     endfunction
   function automatic logic [33:0] e_memrd();       return ev(0,1,1,0,0,-1,-1,0,-1,-1,-1,-1,0);   endfunction
   function automatic logic [33:0] e_memwb();       return ev(0,-1,0,0,0,0,1,1,-1,-1,-1,-1,0);    endfunction
   function automatic logic [33:0] e_memwr();       return ev(0,1,0,1,0,-1,-1,0,-1,-1,-1,-1,0);   endfunction
   function automatic logic [33:0] e_exec(int ac);  return ev(0,-1,0,0,0,-1,-1,0,1,0,-1,ac,0);    endfunction
   function automatic logic [33:0] e_aluwb();       return ev(0,-1,0,0,0,1,0,1,-1,-1,-1,-1,0);    endfunction
   function automatic logic [33:0] e_branch(int pc);return ev(pc,-1,0,0,0,-1,-1,0,1,0,1,6,0);     endfunction
   function automatic logic [33:0] e_addiwb();      return ev(0,-1,0,0,0,0,0,1,-1,-1,-1,-1,0);    endfunction
   function automatic logic [33:0] e_jump();        return ev(1,-1,0,0,0,-1,-1,0,-1,-1,2,-1,0);   endfunction

   task automatic test_reset();
      logic [16:0] obs;
      logic [33:0] e;
      reset = 1'b1;
      bus.opcode = 6'b100011;
      bus.funct = 6'b000000;
      bus.zero = 1'b0;
      bus.mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      obs = pack();
      e = e_reset();
      checks++;
      if ((obs & e[33:17]) !== (e[16:0] & e[33:17])) begin
         failures++;
         $display("FAIL reset_strobes observed=%05h expected=%05h", obs & e[33:17], e[16:0] & e[33:17]);
      end
      checks++;
      if (bus.mem_timeout !== 1'b0) begin
         failures++;
         $display("FAIL reset_timeout observed=%b expected=0", bus.mem_timeout);
      end
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_lw();
      logic [33:0] ex[$];
      logic [16:0] obs;
      bus.opcode = 6'b100011;
      bus.mem_ready = 1'b1;
      ex = '{e_fetch(1), e_decode(0), e_memadr(), e_memrd(), e_memwb()};
      foreach (ex[i]) begin
         @(negedge clk);
         obs = pack();
         checks++;
         if ((obs & ex[i][33:17]) !== (ex[i][16:0] & ex[i][33:17])) begin
            failures++;
            $display("FAIL lw[%0d] observed=%05h expected=%05h", i, obs & ex[i][33:17], ex[i][16:0] & ex[i][33:17]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_rtype(input logic [5:0] fn, input int ac);
      logic [33:0] ex[$];
      logic [16:0] obs;
      bus.opcode = 6'b000000;
      bus.funct = fn;
      bus.mem_ready = 1'b1;
      ex = '{e_fetch(1), e_decode(0), e_exec(ac), e_aluwb()};
      foreach (ex[i]) begin
         @(negedge clk);
         obs = pack();
         checks++;
         if ((obs & ex[i][33:17]) !== (ex[i][16:0] & ex[i][33:17])) begin
            failures++;
            $display("FAIL rtype_%b[%0d] observed=%05h expected=%05h", fn, i, obs & ex[i][33:17], ex[i][16:0] & ex[i][33:17]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_branch(input string name, input logic [5:0] op, input logic z, input int pc);
      logic [33:0] ex[$];
      logic [16:0] obs;
      bus.opcode = op;
      bus.zero = z;
      bus.mem_ready = 1'b1;
      ex = '{e_fetch(1), e_decode(0), e_branch(pc)};
      foreach (ex[i]) begin
         @(negedge clk);
         obs = pack();
         checks++;
         if ((obs & ex[i][33:17]) !== (ex[i][16:0] & ex[i][33:17])) begin
            failures++;
            $display("FAIL %s[%0d] observed=%05h expected=%05h", name, i, obs & ex[i][33:17], ex[i][16:0] & ex[i][33:17]);
         end
         @(posedge clk);
         #1;
      end
      bus.zero = 1'b0;
   endtask

   task automatic test_addi_jump();
      logic [33:0] ex[$];
      logic [16:0] obs;
      logic [5:0]  ops[$];
      bus.mem_ready = 1'b1;
      ex  = '{e_fetch(1), e_decode(0), e_memadr(), e_addiwb(), e_fetch(1), e_decode(0), e_jump()};
      ops = '{6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b000010, 6'b000010, 6'b000010};
      foreach (ex[i]) begin
         bus.opcode = ops[i];
         @(negedge clk);
         obs = pack();
         checks++;
         if ((obs & ex[i][33:17]) !== (ex[i][16:0] & ex[i][33:17])) begin
            failures++;
            $display("FAIL addi_jump[%0d] observed=%05h expected=%05h", i, obs & ex[i][33:17], ex[i][16:0] & ex[i][33:17]);
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_sw_wait();
      logic [33:0] ex[$];
      logic        mr[$];
      logic [16:0] obs;
      bus.opcode = 6'b101011;
      ex = '{e_fetch(1), e_decode(0), e_memadr(), e_memwr(), e_memwr(), e_memwr(),
             e_memwr(), e_memwr(), e_memwr(), e_fetch(0)};
      mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      foreach (ex[i]) begin
         bus.mem_ready = mr[i];
         @(negedge clk);
         obs = pack();
         checks++;
         if ((obs & ex[i][33:17]) !== (ex[i][16:0] & ex[i][33:17])) begin
            failures++;
            $display("FAIL sw_wait[%0d] observed=%05h expected=%05h", i, obs & ex[i][33:17], ex[i][16:0] & ex[i][33:17]);
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (bus.mem_timeout !== 1'b0) begin
         failures++;
         $display("FAIL sw_wait_timeout observed=%b expected=0", bus.mem_timeout);
      end
      bus.mem_ready = 1'b1;
   endtask

   task automatic test_illegal(input string name, input logic [5:0] op, input logic [5:0] fn);
      logic [33:0] ex[$];
      logic        mr[$];
      logic [16:0] obs;
      bus.opcode = op;
      bus.funct = fn;
      ex = '{e_fetch(1), e_decode(1), e_fetch(0)};
      mr = '{1'b1, 1'b1, 1'b0};
      foreach (ex[i]) begin
         bus.mem_ready = mr[i];
         @(negedge clk);
         obs = pack();
         checks++;
         if ((obs & ex[i][33:17]) !== (ex[i][16:0] & ex[i][33:17])) begin
            failures++;
            $display("FAIL %s[%0d] observed=%05h expected=%05h", name, i, obs & ex[i][33:17], ex[i][16:0] & ex[i][33:17]);
         end
         @(posedge clk);
         #1;
      end
      bus.mem_ready = 1'b1;
   endtask

   task automatic test_fetch_timeout();
      logic [16:0] obs;
      logic [33:0] e;
      // A clean jump first so the wait counter starts from zero in FETCH.
      test_addi_jump();
      bus.mem_ready = 1'b0;
      e = e_fetch(0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         obs = pack();
         checks++;
         if ((obs & e[33:17]) !== (e[16:0] & e[33:17])) begin
            failures++;
            $display("FAIL timeout_wait[%0d] observed=%05h expected=%05h", i, obs & e[33:17], e[16:0] & e[33:17]);
         end
         checks++;
         if (bus.mem_timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early[%0d] observed=%b expected=0", i, bus.mem_timeout);
         end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      checks++;
      if (bus.mem_timeout !== 1'b1) begin
         failures++;
         $display("FAIL timeout_set observed=%b expected=1", bus.mem_timeout);
      end
      checks++;
      if (bus.irWrite !== 1'b0) begin
         failures++;
         $display("FAIL timeout_irwrite observed=%b expected=0", bus.irWrite);
      end
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b1;
      test_addi_jump();
      @(negedge clk);
      checks++;
      if (bus.mem_timeout !== 1'b1) begin
         failures++;
         $display("FAIL timeout_sticky observed=%b expected=1", bus.mem_timeout);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      logic [33:0] ex[$];
      logic [16:0] obs;
      logic [33:0] e;
      // The timeout task left the FSM in DECODE; run out via a jump.
      bus.opcode = 6'b000010;
      bus.mem_ready = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      bus.opcode = 6'b100011;
      ex = '{e_fetch(1), e_decode(0), e_memadr(), e_memrd()};
      foreach (ex[i]) begin
         @(negedge clk);
         obs = pack();
         checks++;
         if ((obs & ex[i][33:17]) !== (ex[i][16:0] & ex[i][33:17])) begin
            failures++;
            $display("FAIL reset_mid_lw[%0d] observed=%05h expected=%05h", i, obs & ex[i][33:17], ex[i][16:0] & ex[i][33:17]);
         end
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(negedge clk);
      obs = pack();
      e = e_reset();
      checks++;
      if ((obs & e[33:17]) !== (e[16:0] & e[33:17])) begin
         failures++;
         $display("FAIL reset_mid_memwb observed=%05h expected=%05h", obs & e[33:17], e[16:0] & e[33:17]);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.mem_ready = 1'b0;
      @(negedge clk);
      obs = pack();
      e = e_fetch(0);
      checks++;
      if ((obs & e[33:17]) !== (e[16:0] & e[33:17])) begin
         failures++;
         $display("FAIL reset_mid_fetch observed=%05h expected=%05h", obs & e[33:17], e[16:0] & e[33:17]);
      end
      checks++;
      if (bus.mem_timeout !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_timeout observed=%b expected=0", bus.mem_timeout);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_lw();
      test_rtype(6'b101010, 7);
      test_rtype(6'b100010, 6);
      test_rtype(6'b100000, 2);
      test_rtype(6'b100100, 0);
      test_rtype(6'b100101, 1);
      test_branch("beq_z1", 6'b000100, 1'b1, 1);
      test_branch("beq_z0", 6'b000100, 1'b0, 0);
`ifdef BNE_EN
      test_branch("bne_z1", 6'b000101, 1'b1, 0);
      test_branch("bne_z0", 6'b000101, 1'b0, 1);
`else
      test_illegal("bne_illegal", 6'b000101, 6'b000000);
`endif
      test_addi_jump();
      test_sw_wait();
      test_illegal("op_111111", 6'b111111, 6'b100000);
      test_illegal("funct_000000", 6'b000000, 6'b000000);
      test_fetch_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
